// File: rtl/panel_fb_ctrl_if.sv
// Producer-to-controller pixel write channel: one beat per valid&ready,
// carrying {bank, pixel address}, pixel data and an end-of-frame flag.
interface panel_fb_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              valid;
    logic              ready;
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, addr, data, last, input ready);
    modport slave  (input valid, addr, data, last, output ready);
endinterface

// File: rtl/panel_fb_ctrl.sv
// Ping-pong framebuffer page owner: producer writes and fills go to the back
// page, the scan side reads the front page, and pages swap only on frame sync.
module panel_fb_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    panel_fb_ctrl_if.slave    wr,
    input  logic              i_fill_req,
    input  logic [DATA_W-1:0] i_fill_color,
    input  logic              i_frame_sync,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [ADDR_W:0]   o_mem_rd_addr,
    output logic              o_mem_wr_en,
    output logic              o_mem_wr_bank,
    output logic [ADDR_W:0]   o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data,
    output logic              o_front_page,
    output logic              o_swap_done,
    output logic              o_fill_done,
    output logic [7:0]        o_frame_count
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SWAP_WAIT} state_t;

    localparam logic [ADDR_W+1:0] CNT_ONE = {{(ADDR_W+1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    // Top bit is a terminal flag: set once every pixel of both banks is written.
    logic [ADDR_W+1:0] fill_cnt;
    logic [DATA_W-1:0] fill_color;
    logic              accept, fill_wr, fill_end, swap_now, fill_start;

    assign accept   = wr.valid & wr.ready;
    assign fill_wr  = (state == S_FILL) & ~fill_cnt[ADDR_W+1];
    assign fill_end = (state == S_FILL) &  fill_cnt[ADDR_W+1];
    assign swap_now = (state == S_SWAP_WAIT) & i_frame_sync;

    assign o_mem_rd_addr = {o_front_page, i_rd_addr};

    always_comb begin
        state_nx   = state;
        fill_start = 1'b0;
        case (state)
            S_IDLE: begin
                // A beat beats a fill request; the requester keeps holding it.
                if (accept && wr.last) begin
                    state_nx = S_SWAP_WAIT;
                end else if (i_fill_req && !wr.valid) begin
                    state_nx   = S_FILL;
                    fill_start = 1'b1;
                end
            end
            S_FILL:      if (fill_end) state_nx = S_IDLE;
            S_SWAP_WAIT: if (i_frame_sync) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            wr.ready      <= 1'b0;
            fill_cnt      <= '0;
            fill_color    <= '0;
            o_mem_wr_en   <= 1'b0;
            o_mem_wr_bank <= 1'b0;
            o_mem_wr_addr <= '0;
            o_mem_wr_data <= '0;
            o_front_page  <= 1'b0;
            o_swap_done   <= 1'b0;
            o_fill_done   <= 1'b0;
            o_frame_count <= '0;
        end else begin
            state       <= state_nx;
            wr.ready    <= (state_nx == S_IDLE);
            o_mem_wr_en <= accept | fill_wr;
            o_swap_done <= swap_now;
            o_fill_done <= fill_end;

            if (accept) begin
                o_mem_wr_bank <= wr.addr[ADDR_W];
                o_mem_wr_addr <= {~o_front_page, wr.addr[ADDR_W-1:0]};
                o_mem_wr_data <= wr.data;
            end else if (fill_wr) begin
                o_mem_wr_bank <= fill_cnt[ADDR_W];
                o_mem_wr_addr <= {~o_front_page, fill_cnt[ADDR_W-1:0]};
                o_mem_wr_data <= fill_color;
            end

            if (fill_start) begin
                fill_cnt   <= '0;
                fill_color <= i_fill_color;
            end else if (fill_wr) begin
                fill_cnt <= fill_cnt + CNT_ONE;
            end

            if (swap_now) begin
                o_front_page  <= ~o_front_page;
                o_frame_count <= o_frame_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_panel_fb_ctrl.sv
// Randomised scoreboard bench for panel_fb_ctrl against a frame-level model.
module tb_panel_fb_ctrl;
    localparam int AW   = 11;
    localparam int DW   = 16;
    localparam int NPIX = 1 << (AW + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    panel_fb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) wif ();

    logic          fill_req   = 1'b0;
    logic [DW-1:0] fill_color = '0;
    logic          sync       = 1'b0;
    logic [AW-1:0] rd_addr    = '0;
    logic [AW:0]   mem_rd_addr;
    logic          wr_en, wr_bank, front, swap_done, fill_done;
    logic [AW:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    frame_count;

    panel_fb_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst), .wr(wif.slave),
        .i_fill_req(fill_req), .i_fill_color(fill_color),
        .i_frame_sync(sync), .i_rd_addr(rd_addr),
        .o_mem_rd_addr(mem_rd_addr), .o_mem_wr_en(wr_en),
        .o_mem_wr_bank(wr_bank), .o_mem_wr_addr(wr_addr),
        .o_mem_wr_data(wr_data), .o_front_page(front),
        .o_swap_done(swap_done), .o_fill_done(fill_done),
        .o_frame_count(frame_count)
    );

    typedef struct packed {
        logic          bank;
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    // Reference model: frame-level view (idle / filling / awaiting sync).
    bit            m_front   = 0;
    int            m_count   = 0;
    int            m_mode    = 0;   // 0 idle, 1 filling, 2 awaiting sync
    int            m_idx     = 0;
    logic [DW-1:0] m_color   = '0;
    bit            exp_ready = 0, exp_wen = 0, exp_swap = 0, exp_fd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_front = 0; m_count = 0; m_mode = 0;
            exp_ready = 0; exp_wen = 0; exp_swap = 0; exp_fd = 0;
            wq.delete();
        end else begin
            exp_wen = 0; exp_swap = 0; exp_fd = 0;
            if (m_mode == 0) begin
                if (exp_ready && wif.valid) begin
                    wq.push_back(wr_t'{wif.addr[AW], {~m_front, wif.addr[AW-1:0]}, wif.data});
                    exp_wen = 1;
                    if (wif.last) m_mode = 2;
                end else if (fill_req && !wif.valid) begin
                    m_mode = 1; m_idx = 0; m_color = fill_color;
                end
            end else if (m_mode == 1) begin
                if (m_idx < NPIX) begin
                    logic [AW:0] p;
                    p = m_idx[AW:0];
                    wq.push_back(wr_t'{p[AW], {~m_front, p[AW-1:0]}, m_color});
                    exp_wen = 1;
                    m_idx++;
                end else begin
                    m_mode = 0; exp_fd = 1;
                end
            end else if (sync) begin
                m_front  = ~m_front;
                m_count  = (m_count + 1) % 256;
                exp_swap = 1;
                m_mode   = 0;
            end
            exp_ready = (m_mode == 0);
        end
    end

    // Monitor: compares every cycle, pops the scoreboard on each RAM write.
    initial forever begin
        wr_t e;
        @(negedge clk);
        chk("wr_ready",    wif.ready,   exp_ready);
        chk("wr_en",       wr_en,       exp_wen);
        chk("swap_done",   swap_done,   exp_swap);
        chk("fill_done",   fill_done,   exp_fd);
        chk("front_page",  front,       m_front);
        chk("frame_count", frame_count, m_count);
        chk("mem_rd_addr", mem_rd_addr, {m_front, rd_addr});
        if (rst) begin
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_bank", wr_bank, 0);
            chk("rst_wr_data", wr_data, 0);
        end
        if (wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                e = wq.pop_front();
                chk("sb_bank", wr_bank, e.bank);
                chk("sb_addr", wr_addr, e.addr);
                chk("sb_data", wr_data, e.data);
            end
        end
    end

    task automatic cyc(input logic v, input logic [AW:0] a, input logic [DW-1:0] d,
                       input logic l, input logic f, input logic s);
        wif.valid = v; wif.addr = a; wif.data = d; wif.last = l;
        fill_req = f; sync = s; rd_addr = AW'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 12'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", wif.ready, 0);
        chk("rst_wen",   wr_en, 0);
        chk("rst_front", front, 0);
        chk("rst_count", frame_count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        wif.valid = 1'b0; wif.addr = '0; wif.data = '0; wif.last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // First beat after reset lands on back page 1, bank 1.
        idle(1);
        cyc(1'b1, 12'h805, 16'hF800, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_wen", wr_en, 1); chk("t1_bank", wr_bank, 1);
        chk("t1_addr", wr_addr, 12'h805); chk("t1_data", wr_data, 16'hF800);
        chk("t1_front", front, 0);

        // Full frame, last beat, sync 10 cycles later.
        for (int i = 0; i < NPIX; i++)
            cyc(1'b1, i[AW:0], 16'($urandom), i == NPIX - 1, 1'b0, 1'b0);
        idle(9);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_front", front, 1); chk("t2_count", frame_count, 1);
        chk("t2_swap", swap_done, 1);
        cyc(1'b1, 12'h123, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_swap_pulse", swap_done, 0);
        chk("t2_page0", wr_addr, 12'h123);

        // Last beat coincident with sync: only the next sync swaps.
        cyc(1'b1, 12'h010, 16'h0001, 1'b1, 1'b0, 1'b1);
        idle(3);
        chk("t3_noswap", front, 1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("t3_swap", front, 0);
        chk("t3_count", frame_count, 2);

        // Fill with beats offered throughout (none must be taken).
        fill_color = 16'h07E0;
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        repeat (NPIX + 4) cyc(1'($urandom), 12'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);

        // Beat and fill request together: beat first, fill next cycle.
        fill_color = 16'h001F;
        cyc(1'b1, 12'h7FF, 16'h1234, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(NPIX + 4);

        // Reset mid-fill: the fill is abandoned, writes resume on page 1.
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1001);
        reset_pulse();
        idle(1);
        cyc(1'b1, 12'h0AB, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_page1", wr_addr, 12'h8AB);
        idle(8);

        // Reset while awaiting sync.
        cyc(1'b1, 12'h001, 16'h5555, 1'b1, 1'b0, 1'b0);
        idle(3);
        reset_pulse();
        idle(1);
        cyc(1'b1, 12'h002, 16'h6666, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t7_page1", wr_addr, 12'h802);

        // 256 swaps wrap the frame counter.
        repeat (256) begin
            cyc(1'b1, 12'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
            cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        chk("t8_wrap", frame_count, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            fill_color = 16'($urandom);
            cyc(($urandom % 4) != 0, 12'($urandom), 16'($urandom),
                ($urandom % 16) == 0, ($urandom % 400) == 0, ($urandom % 8) == 0);
        end
        idle(NPIX + 8);
        chk("sb_drained", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/panel_fb_ctrl.md
# panel_fb_ctrl

Ping-pong framebuffer controller between the frame producer (image loader/decoder) and the panel scan driver. It owns the page bit of the dual-bank panel RAM. Writes and hardware fills always land in the back page, while the scan driver reads only the front page. Pages swap only on a frame-sync boundary from the scan side, so the panel never shows a torn frame.

## Interface
- ADDR_W, 11: per-bank pixel address width (2048 pixels per bank; bank 0 = upper rows/b1, bank 1 = lower rows/b2)
- DATA_W, 16: pixel width (RGB565)

Clock, reset and ports:
- i_clk  in  1  sole clock
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_wr_valid  in  1  producer pixel beat valid
- o_wr_ready  out  1  controller accepts a beat when valid&ready
- i_wr_addr  in  ADDR_W+1  {bank, pixel address}
- i_wr_data  in  DATA_W  pixel value
- i_wr_last  in  1  final beat of a frame; requests a swap
- i_fill_req  in  1  level request to fill the whole back page with i_fill_color
- i_fill_color  in  DATA_W  fill value, sampled when the fill starts
- i_frame_sync  in  1  one-cycle pulse from the scan driver at the start of a full scan
- i_rd_addr  in  ADDR_W  scan-driver read address
- o_mem_rd_addr  out  ADDR_W+1  {front_page, i_rd_addr}, combinational
- o_mem_wr_en  out  1  RAM write strobe
- o_mem_wr_bank  out  1  selects the b1 (0) or b2 (1) RAM
- o_mem_wr_addr  out  ADDR_W+1  {back_page, pixel address}
- o_mem_wr_data  out  DATA_W  RAM write data
- o_front_page  out  1  current displayed page
- o_swap_done  out  1  one-cycle pulse when a swap occurs
- o_fill_done  out  1  one-cycle pulse when a fill completes
- o_frame_count  out  8  number of swaps, wraps 255 -> 0

## Operation
- back_page = ~front_page at all times.
- States:
  - S_IDLE: accepts beats.
    - Accepted beat with i_wr_last -> S_SWAP_WAIT.
    - i_fill_req high while i_wr_valid is low -> S_FILL: counter cleared, colour latched.
    - i_fill_req with i_wr_valid both high: the beat wins and the fill is not started. The requester holds i_fill_req.
  - S_FILL: one RAM write per cycle, counter 0..2^(ADDR_W+1)-1.
    - Bank = counter MSB; address = counter low ADDR_W bits.
    - After the write of the last counter value -> S_IDLE with an o_fill_done pulse.
  - S_SWAP_WAIT: no beats accepted. On i_frame_sync: front_page toggles, o_frame_count increments, o_swap_done pulses, -> S_IDLE.
- i_frame_sync in S_IDLE or S_FILL has no effect.
- i_fill_req outside S_IDLE is ignored.
- i_wr_last together with a same-cycle i_frame_sync does not swap on that pulse. The swap waits for the next sync, which guarantees at least one complete scan of the old front page.
- Reset (asynchronous, any state, including mid-fill or mid-swap-wait):
  - state S_IDLE, front_page 0, fill counter 0, o_frame_count 0.
  - o_wr_ready, o_mem_wr_en, o_swap_done and o_fill_done are 0; o_mem_wr_addr, o_mem_wr_bank and o_mem_wr_data are 0.
  - An in-progress fill is abandoned and is not resumed.

## Timing
- o_wr_ready is registered from next-state == S_IDLE.
  - It is 0 during reset and goes to 1 at the first edge after reset release.
  - It drops at the same edge that accepts a last beat, so no beat after the last is taken.
- Accepted beat -> o_mem_wr_en, bank, address and data valid exactly 1 cycle later, for 1 cycle. Throughput is 1 beat/cycle.
- Fill:
  - First write is 1 cycle after S_FILL entry.
  - Duration is 4096 cycles at the default widths.
  - o_fill_done asserts in the cycle after the last write is presented; o_wr_ready returns to 1 in that same cycle.
- Swap:
  - front_page, o_mem_rd_addr MSB and o_frame_count update at the edge that samples i_frame_sync.
  - o_swap_done is high in the following cycle, and o_wr_ready returns to 1 in that same cycle.
- o_mem_rd_addr has zero latency from i_rd_addr, so scan-side read timing is unchanged.

## Test plan
- Reset release then a beat (addr 0x805, data 0xF800) -> 1 cycle later: wr_en=1, bank=1, wr_addr=0x805 (back page 1, bank 1, address 0x005), data=0xF800; front_page=0.
- Stream 4096 beats, last beat flagged, sync pulse 10 cycles later -> ready low from the last-beat edge; swap at the sync edge; o_front_page=1, o_frame_count=1, o_swap_done is a single cycle; subsequent writes use page bit 0.
- Last beat and i_frame_sync in the same cycle -> no swap; the second sync swaps.
- Fill with colour 0x07E0 -> 4096 consecutive writes: addresses 0..2047 on bank 0 then bank 1, all with data 0x07E0 on the back page; o_fill_done single pulse; no beats accepted meanwhile.
- i_fill_req and i_wr_valid together in S_IDLE -> the beat is written first; the fill starts the next cycle.
- i_rst asserted at fill count 1000, or while in S_SWAP_WAIT -> immediately wr_en=0, ready=0, front_page=0, count=0; after release, writes resume at page 1 and no fill continues.
- 256 swaps -> o_frame_count wraps to 0.
